// File: rtl/commit_ctrl_if.sv
// Head-of-ROB / commit handshake bundle between the reorder buffer, the
// register file, the load-store buffer and the commit sequencer.
interface commit_ctrl_if #(
   parameter int ROB_WIDTH = 4,
   parameter int REG_WIDTH = 5
) ();
   logic                 head_valid;
   logic                 head_ready;
   logic [1:0]           head_type;
   logic [ROB_WIDTH-1:0] head_rob_id;
   logic [REG_WIDTH-1:0] head_reg_id;
   logic [31:0]          head_data;
   logic                 head_mispredict;
   logic [31:0]          head_target_pc;
   logic                 store_done;

   logic                 rob_pop;
   logic [REG_WIDTH-1:0] commit_reg_id;
   logic [31:0]          commit_data;
   logic [ROB_WIDTH-1:0] commit_rob_id;
   logic                 store_req;
   logic [ROB_WIDTH-1:0] store_rob_id;
   logic                 flush;
   logic [31:0]          flush_pc;
   logic                 halted;
   logic [31:0]          commit_count;

   modport master (
      output head_valid, head_ready, head_type, head_rob_id, head_reg_id,
             head_data, head_mispredict, head_target_pc, store_done,
      input  rob_pop, commit_reg_id, commit_data, commit_rob_id, store_req,
             store_rob_id, flush, flush_pc, halted, commit_count
   );

   modport slave (
      input  head_valid, head_ready, head_type, head_rob_id, head_reg_id,
             head_data, head_mispredict, head_target_pc, store_done,
      output rob_pop, commit_reg_id, commit_data, commit_rob_id, store_req,
             store_rob_id, flush, flush_pc, halted, commit_count
   );
endinterface

// File: rtl/commit_ctrl.sv
// In-order retirement sequencer: retires, holds or stalls the ROB head and
// drives the register-file commit port, store requests, flush and halt.
module commit_ctrl #(
   parameter int ROB_WIDTH    = 4,
   parameter int REG_WIDTH    = 5,
   parameter int FLUSH_CYCLES = 1
) (
   input  logic         clk_in,
   input  logic         rst_in,
   input  logic         rdy_in,
   commit_ctrl_if.slave bus
);

   typedef enum logic [1:0] {RUN, STORE_WAIT, FLUSH, HALT} state_t;

   localparam logic [1:0] TYPE_REG    = 2'd0;
   localparam logic [1:0] TYPE_STORE  = 2'd1;
   localparam logic [1:0] TYPE_BRANCH = 2'd2;
   localparam logic [1:0] TYPE_EXIT   = 2'd3;

   state_t               r_state;
   logic                 r_flush;
   logic [31:0]          r_flushPc;
   logic                 r_halted;
   logic [31:0]          r_commitCount;
   logic [31:0]          r_flushCnt;
   logic [ROB_WIDTH-1:0] r_storeRobId;

   logic                 w_retireable;
   logic                 w_robPop;
   logic [REG_WIDTH-1:0] w_commitRegId;
   logic [31:0]          w_commitData;
   logic [ROB_WIDTH-1:0] w_commitRobId;
   logic                 w_storeReq;

   assign w_retireable = rdy_in && (r_state == RUN) && bus.head_valid && bus.head_ready;

   always_comb begin
      w_robPop      = 1'b0;
      w_commitRegId = '0;
      w_commitData  = '0;
      w_commitRobId = '0;
      w_storeReq    = 1'b0;
      if (w_retireable) begin
         case (bus.head_type)
            TYPE_REG, TYPE_BRANCH: begin
               w_robPop      = 1'b1;
               w_commitRegId = bus.head_reg_id;
               w_commitData  = bus.head_data;
               w_commitRobId = bus.head_rob_id;
            end
            TYPE_STORE: w_storeReq = 1'b1;
            default: begin
               w_robPop      = 1'b1;
               w_commitRobId = bus.head_rob_id;
            end
         endcase
      end else if (rdy_in && (r_state == STORE_WAIT) && bus.store_done) begin
         w_robPop      = 1'b1;
         w_commitRobId = bus.head_rob_id;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state       <= RUN;
         r_flush       <= 1'b0;
         r_flushPc     <= '0;
         r_halted      <= 1'b0;
         r_commitCount <= '0;
         r_flushCnt    <= '0;
         r_storeRobId  <= '0;
      end else if (rdy_in) begin
         case (r_state)
            RUN: begin
               if (w_retireable) begin
                  case (bus.head_type)
                     TYPE_REG: r_commitCount <= r_commitCount + 32'd1;
                     TYPE_STORE: begin
                        r_storeRobId <= bus.head_rob_id;
                        r_state      <= STORE_WAIT;
                     end
                     TYPE_BRANCH: begin
                        r_commitCount <= r_commitCount + 32'd1;
                        if (bus.head_mispredict) begin
                           r_flush    <= 1'b1;
                           r_flushPc  <= bus.head_target_pc;
                           r_flushCnt <= 32'(FLUSH_CYCLES - 1);
                           r_state    <= FLUSH;
                        end
                     end
                     default: begin
                        r_commitCount <= r_commitCount + 32'd1;
                        r_halted      <= 1'b1;
                        r_state       <= HALT;
                     end
                  endcase
               end
            end
            STORE_WAIT: begin
               if (bus.store_done) begin
                  r_commitCount <= r_commitCount + 32'd1;
                  r_state       <= RUN;
               end
            end
            FLUSH: begin
               // The counter reaching zero marks the last flush cycle.
               if (r_flushCnt == 32'd0) begin
                  r_flush <= 1'b0;
                  r_state <= RUN;
               end else begin
                  r_flushCnt <= r_flushCnt - 32'd1;
               end
            end
            default: r_state <= HALT;
         endcase
      end
   end

   assign bus.rob_pop       = w_robPop;
   assign bus.commit_reg_id = w_commitRegId;
   assign bus.commit_data   = w_commitData;
   assign bus.commit_rob_id = w_commitRobId;
   assign bus.store_req     = w_storeReq;
   // The store id is visible in the request cycle and then held for the LSB.
   assign bus.store_rob_id  = w_storeReq ? bus.head_rob_id : r_storeRobId;
   assign bus.flush         = r_flush;
   assign bus.flush_pc      = r_flushPc;
   assign bus.halted        = r_halted;
   assign bus.commit_count  = r_commitCount;

endmodule

// File: tb/tb_commit_ctrl.sv
// Directed bench for commit_ctrl: REG/STORE/BRANCH/EXIT retirement, flush
// timing, rdy_in stalls, head_ready stalls and reset recovery.
module tb_commit_ctrl;

   logic clk;
   logic rst;
   logic rdy;
   int   checks;
   int   failures;

   commit_ctrl_if #(.ROB_WIDTH(4), .REG_WIDTH(5)) bus ();

   commit_ctrl #(.ROB_WIDTH(4), .REG_WIDTH(5), .FLUSH_CYCLES(2)) dut (
      .clk_in (clk),
      .rst_in (rst),
      .rdy_in (rdy),
      .bus    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic ready, input logic [1:0] htype,
                                input logic [3:0] robId, input logic [4:0] regId,
                                input logic [31:0] data, input logic mis, input logic [31:0] target);
      bus.head_valid      = valid;
      bus.head_ready      = ready;
      bus.head_type       = htype;
      bus.head_rob_id     = robId;
      bus.head_reg_id     = regId;
      bus.head_data       = data;
      bus.head_mispredict = mis;
      bus.head_target_pc  = target;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst = 1'b1;
      rdy = 1'b1;
      bus.store_done = 1'b0;
      applyStimulus(0, 0, 2'd0, 4'd0, 5'd0, 32'd0, 0, 32'd0);
      tick();
      tick();
      rst = 1'b0;

      checkOutput("rst_flush", 32'(bus.flush), 32'd0);
      checkOutput("rst_flush_pc", bus.flush_pc, 32'd0);
      checkOutput("rst_halted", 32'(bus.halted), 32'd0);
      checkOutput("rst_count", bus.commit_count, 32'd0);
      checkOutput("rst_store_rob_id", 32'(bus.store_rob_id), 32'd0);
      checkOutput("rst_pop", 32'(bus.rob_pop), 32'd0);

      // REG retirement, zero latency
      applyStimulus(1, 1, 2'd0, 4'd3, 5'd5, 32'hDEADBEEF, 0, 32'd0);
      checkOutput("reg_pop", 32'(bus.rob_pop), 32'd1);
      checkOutput("reg_regid", 32'(bus.commit_reg_id), 32'd5);
      checkOutput("reg_data", bus.commit_data, 32'hDEADBEEF);
      checkOutput("reg_robid", 32'(bus.commit_rob_id), 32'd3);
      checkOutput("reg_store_req", 32'(bus.store_req), 32'd0);
      tick();
      checkOutput("reg_count", bus.commit_count, 32'd1);
      applyStimulus(0, 0, 2'd0, 4'd0, 5'd0, 32'd0, 0, 32'd0);
      checkOutput("idle_pop", 32'(bus.rob_pop), 32'd0);

      // STORE with store_done three cycles after the request
      applyStimulus(1, 1, 2'd1, 4'd6, 5'd7, 32'h1234, 0, 32'd0);
      checkOutput("st_req", 32'(bus.store_req), 32'd1);
      checkOutput("st_robid", 32'(bus.store_rob_id), 32'd6);
      checkOutput("st_pop", 32'(bus.rob_pop), 32'd0);
      checkOutput("st_regid", 32'(bus.commit_reg_id), 32'd0);
      tick();
      for (int i = 0; i < 2; i++) begin
         checkOutput("st_wait_req", 32'(bus.store_req), 32'd0);
         checkOutput("st_wait_pop", 32'(bus.rob_pop), 32'd0);
         checkOutput("st_wait_robid", 32'(bus.store_rob_id), 32'd6);
         tick();
      end
      bus.store_done = 1'b1;
      #1;
      checkOutput("st_done_pop", 32'(bus.rob_pop), 32'd1);
      checkOutput("st_done_regid", 32'(bus.commit_reg_id), 32'd0);
      checkOutput("st_done_robid", 32'(bus.commit_rob_id), 32'd6);
      checkOutput("st_done_req", 32'(bus.store_req), 32'd0);
      tick();
      checkOutput("st_count", bus.commit_count, 32'd2);
      applyStimulus(0, 0, 2'd0, 4'd0, 5'd0, 32'd0, 0, 32'd0);
      checkOutput("st_done_run_pop", 32'(bus.rob_pop), 32'd0);
      tick();
      bus.store_done = 1'b0;
      checkOutput("st_done_run_count", bus.commit_count, 32'd2);

      // Mispredicted branch with link write, then flush for two cycles
      applyStimulus(1, 1, 2'd2, 4'd2, 5'd1, 32'h1004, 1, 32'h2000);
      checkOutput("br_pop", 32'(bus.rob_pop), 32'd1);
      checkOutput("br_regid", 32'(bus.commit_reg_id), 32'd1);
      checkOutput("br_data", bus.commit_data, 32'h1004);
      tick();
      checkOutput("br_flush1", 32'(bus.flush), 32'd1);
      checkOutput("br_flush_pc", bus.flush_pc, 32'h2000);
      checkOutput("br_count", bus.commit_count, 32'd3);
      applyStimulus(1, 1, 2'd0, 4'd4, 5'd9, 32'h55, 0, 32'd0);
      checkOutput("fl_pop1", 32'(bus.rob_pop), 32'd0);
      tick();
      checkOutput("br_flush2", 32'(bus.flush), 32'd1);
      checkOutput("fl_pop2", 32'(bus.rob_pop), 32'd0);
      tick();
      checkOutput("br_flush_drop", 32'(bus.flush), 32'd0);
      checkOutput("fl_resume_pop", 32'(bus.rob_pop), 32'd1);
      checkOutput("fl_resume_regid", 32'(bus.commit_reg_id), 32'd9);
      tick();
      checkOutput("fl_resume_count", bus.commit_count, 32'd4);

      // rdy_in stall in the middle of a flush stretches it
      applyStimulus(1, 1, 2'd2, 4'd5, 5'd0, 32'd0, 1, 32'h3000);
      checkOutput("br2_pop", 32'(bus.rob_pop), 32'd1);
      checkOutput("br2_regid", 32'(bus.commit_reg_id), 32'd0);
      tick();
      checkOutput("br2_flush", 32'(bus.flush), 32'd1);
      checkOutput("br2_count", bus.commit_count, 32'd5);
      rdy = 1'b0;
      applyStimulus(1, 1, 2'd0, 4'd7, 5'd3, 32'h77, 0, 32'd0);
      for (int i = 0; i < 4; i++) begin
         checkOutput("stall_pop", 32'(bus.rob_pop), 32'd0);
         tick();
         checkOutput("stall_flush", 32'(bus.flush), 32'd1);
         checkOutput("stall_count", bus.commit_count, 32'd5);
      end
      rdy = 1'b1;
      #1;
      checkOutput("unstall_pop", 32'(bus.rob_pop), 32'd0);
      tick();
      checkOutput("unstall_flush2", 32'(bus.flush), 32'd1);
      tick();
      checkOutput("unstall_flush_drop", 32'(bus.flush), 32'd0);
      checkOutput("unstall_retire_pop", 32'(bus.rob_pop), 32'd1);
      tick();
      checkOutput("unstall_count", bus.commit_count, 32'd6);
      rdy = 1'b0;
      #1;
      checkOutput("run_stall_pop", 32'(bus.rob_pop), 32'd0);
      tick();
      checkOutput("run_stall_count", bus.commit_count, 32'd6);
      applyStimulus(0, 0, 2'd0, 4'd0, 5'd0, 32'd0, 0, 32'd0);
      rdy = 1'b1;

      // head_ready low for five cycles
      applyStimulus(1, 0, 2'd0, 4'd8, 5'd2, 32'hA5, 0, 32'd0);
      for (int i = 0; i < 5; i++) begin
         checkOutput("nr_pop", 32'(bus.rob_pop), 32'd0);
         tick();
         checkOutput("nr_count", bus.commit_count, 32'd6);
      end
      applyStimulus(1, 1, 2'd0, 4'd8, 5'd2, 32'hA5, 0, 32'd0);
      checkOutput("nr_ready_pop", 32'(bus.rob_pop), 32'd1);
      checkOutput("nr_ready_data", bus.commit_data, 32'hA5);
      tick();
      checkOutput("nr_ready_count", bus.commit_count, 32'd7);

      // EXIT halts until reset
      applyStimulus(1, 1, 2'd3, 4'd9, 5'd4, 32'd1, 0, 32'd0);
      checkOutput("exit_pop", 32'(bus.rob_pop), 32'd1);
      checkOutput("exit_regid", 32'(bus.commit_reg_id), 32'd0);
      tick();
      checkOutput("exit_halted", 32'(bus.halted), 32'd1);
      checkOutput("exit_count", bus.commit_count, 32'd8);
      applyStimulus(1, 1, 2'd0, 4'd10, 5'd6, 32'h66, 0, 32'd0);
      for (int i = 0; i < 3; i++) begin
         checkOutput("halt_pop", 32'(bus.rob_pop), 32'd0);
         tick();
         checkOutput("halt_halted", 32'(bus.halted), 32'd1);
         checkOutput("halt_count", bus.commit_count, 32'd8);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("halt_rst_halted", 32'(bus.halted), 32'd0);
      checkOutput("halt_rst_count", bus.commit_count, 32'd0);

      // Reset in the middle of a flush returns straight to RUN
      applyStimulus(1, 1, 2'd2, 4'd1, 5'd0, 32'd0, 1, 32'h4000);
      tick();
      checkOutput("rstfl_flush", 32'(bus.flush), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("rstfl_flush_clear", 32'(bus.flush), 32'd0);
      applyStimulus(1, 1, 2'd0, 4'd11, 5'd8, 32'h99, 0, 32'd0);
      checkOutput("rstfl_run_pop", 32'(bus.rob_pop), 32'd1);
      tick();
      checkOutput("rstfl_count", bus.commit_count, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
